// File: rtl/stack_alu_sequencer.sv
// RPN token sequencer in front of a STACK_BASED_ALU: turns operand/ADD/MULT/END tokens
// into PUSH/POP/op opcode sequences, tracks stack depth and reports results and errors.
module stack_alu_sequencer #(
  parameter int DATA_WIDTH = 4,
  parameter int STACK_SIZE = 64,
  localparam int DEPTH_W = $clog2(STACK_SIZE + 1),
  localparam int CNT_W = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [1:0]            tok_type,
  input  logic [DATA_WIDTH-1:0] tok_data,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_input_data,
  input  logic [DATA_WIDTH-1:0] alu_output_data,
  input  logic                  alu_overflow,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_overflow,
  output logic                  err,
  output logic [DEPTH_W-1:0]    depth
);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_PUSH, S_OP, S_CAP, S_POP1, S_POP2, S_PUSHR,
    S_FIN_POP, S_FIN_CAP, S_ERR, S_FLUSH
  } state_t;

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_ADD  = 3'b100;
  localparam logic [2:0] OPC_MULT = 3'b101;
  localparam logic [2:0] OPC_PUSH = 3'b110;
  localparam logic [2:0] OPC_POP  = 3'b111;

  localparam logic [1:0] TOK_OPND = 2'b00;
  localparam logic [1:0] TOK_ADD  = 2'b01;
  localparam logic [1:0] TOK_MULT = 2'b10;
  localparam logic [1:0] TOK_END  = 2'b11;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_SIZE);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);
  localparam logic [CNT_W-1:0]   INIT_LAST  = CNT_W'(STACK_SIZE - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_init_cnt;
  logic [DEPTH_W-1:0]    r_depth;
  logic                  r_acc;
  logic [DATA_WIDTH-1:0] r_tmp;
  logic [2:0]            r_opcode;
  logic [DATA_WIDTH-1:0] r_in;
  logic                  r_ready;
  logic                  r_res_valid;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_ovf;
  logic                  r_err;

  // Depth saturates at both ends so it can never wrap.
  function automatic logic [DEPTH_W-1:0] dep_inc(input logic [DEPTH_W-1:0] d);
    return (d >= DEPTH_FULL) ? DEPTH_FULL : d + DEPTH_ONE;
  endfunction

  function automatic logic [DEPTH_W-1:0] dep_dec(input logic [DEPTH_W-1:0] d);
    return (d == '0) ? '0 : d - DEPTH_ONE;
  endfunction

  // Outputs are registered for the state being entered, so they act as Moore outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_init_cnt  <= '0;
      r_depth     <= '0;
      r_acc       <= 1'b0;
      r_opcode    <= OPC_POP;
      r_in        <= '0;
      r_ready     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_ovf   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_opcode    <= OPC_NOP;
      r_in        <= '0;
      r_ready     <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + CNT_W'(1);
            r_opcode   <= OPC_POP;
          end
        end
        S_IDLE: begin
          if (tok_valid) begin
            case (tok_type)
              TOK_OPND: begin
                if (r_depth < DEPTH_FULL) begin
                  r_state  <= S_PUSH;
                  r_opcode <= OPC_PUSH;
                  r_in     <= tok_data;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                end
              end
              TOK_ADD, TOK_MULT: begin
                if (r_depth >= DEPTH_TWO) begin
                  r_state  <= S_OP;
                  r_opcode <= (tok_type == TOK_ADD) ? OPC_ADD : OPC_MULT;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                end
              end
              TOK_END: begin
                if (r_depth == DEPTH_ONE) begin
                  r_state  <= S_FIN_POP;
                  r_opcode <= OPC_POP;
                end else begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_ready <= 1'b1;
          end
        end
        S_PUSH: begin
          r_depth <= dep_inc(r_depth);
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        S_OP: r_state <= S_CAP;
        // ALU result is visible one cycle after the op was sampled.
        S_CAP: begin
          r_tmp    <= alu_output_data;
          r_acc    <= r_acc | alu_overflow;
          r_state  <= S_POP1;
          r_opcode <= OPC_POP;
        end
        S_POP1: begin
          r_depth  <= dep_dec(r_depth);
          r_state  <= S_POP2;
          r_opcode <= OPC_POP;
        end
        S_POP2: begin
          r_depth  <= dep_dec(r_depth);
          r_state  <= S_PUSHR;
          r_opcode <= OPC_PUSH;
          r_in     <= r_tmp;
        end
        S_PUSHR: begin
          r_depth <= dep_inc(r_depth);
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        S_FIN_POP: begin
          r_depth <= dep_dec(r_depth);
          r_state <= S_FIN_CAP;
        end
        S_FIN_CAP: begin
          r_res_data  <= alu_output_data;
          r_res_ovf   <= r_acc;
          r_res_valid <= 1'b1;
          r_acc       <= 1'b0;
          r_state     <= S_IDLE;
          r_ready     <= 1'b1;
        end
        S_ERR: begin
          r_acc <= 1'b0;
          if (r_depth != '0) begin
            r_state  <= S_FLUSH;
            r_opcode <= OPC_POP;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_depth <= dep_dec(r_depth);
          if (r_depth <= DEPTH_ONE) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_opcode <= OPC_POP;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign tok_ready      = r_ready;
  assign alu_opcode     = r_opcode;
  assign alu_input_data = r_in;
  assign res_valid      = r_res_valid;
  assign res_data       = r_res_data;
  assign res_overflow   = r_res_ovf;
  assign err            = r_err;
  assign depth          = r_depth;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer: behavioural stack ALU, RPN reference model and
// result scoreboard, with one task per scenario.
module tb_stack_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tok_valid = 1'b0;
  logic       tok_ready;
  logic [1:0] tok_type = 2'b00;
  logic [3:0] tok_data = 4'h0;
  logic [2:0] alu_opcode;
  logic [3:0] alu_input_data;
  logic [3:0] alu_output_data;
  logic       alu_overflow;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_overflow;
  logic       err;
  logic [6:0] depth;

  int total = 0;
  int bad = 0;
  int obs_err = 0;
  int exp_err = 0;
  int saw_push = 0;
  bit watch_push = 1'b0;
  bit rec_en = 1'b0;

  int         m_stk[$];
  bit         m_acc = 1'b0;
  logic [4:0] sb[$];
  logic [6:0] tr[$];

  stack_alu_sequencer #(.DATA_WIDTH(4), .STACK_SIZE(64)) dut (
    .clk(clk), .rst_n(rst_n), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_type(tok_type), .tok_data(tok_data), .alu_opcode(alu_opcode),
    .alu_input_data(alu_input_data), .alu_output_data(alu_output_data),
    .alu_overflow(alu_overflow), .res_valid(res_valid), .res_data(res_data),
    .res_overflow(res_overflow), .err(err), .depth(depth)
  );

  always #5 clk = ~clk;

  // Behavioural STACK_BASED_ALU
  logic [3:0] a_stk [64];
  logic [6:0] a_sp = 7'd0;
  logic [3:0] a_out = 4'h0;
  logic       a_ovf = 1'b0;
  logic [5:0] w_i0, w_i1;
  logic [4:0] w_sum;
  logic [7:0] w_prod;
  assign w_i0 = a_sp[5:0] - 6'd1;
  assign w_i1 = a_sp[5:0] - 6'd2;
  assign w_sum = {1'b0, a_stk[w_i0]} + {1'b0, a_stk[w_i1]};
  assign w_prod = {4'h0, a_stk[w_i0]} * {4'h0, a_stk[w_i1]};
  assign alu_output_data = a_out;
  assign alu_overflow = a_ovf;

  always @(posedge clk) begin
    a_ovf <= 1'b0;
    case (alu_opcode)
      3'b110: if (a_sp < 7'd64) begin a_stk[a_sp[5:0]] <= alu_input_data; a_sp <= a_sp + 7'd1; end
      3'b111: if (a_sp > 7'd0) begin a_out <= a_stk[w_i0]; a_sp <= a_sp - 7'd1; end
      3'b100: if (a_sp >= 7'd2) begin a_out <= w_sum[3:0]; a_ovf <= w_sum[4]; end
      3'b101: if (a_sp >= 7'd2) begin a_out <= w_prod[3:0]; a_ovf <= (w_prod[7:4] != 4'h0); end
      default: ;
    endcase
  end

  // Result scoreboard and error/opcode monitors
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (res_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL res_unexpected: got data=%0h ovf=%b, required no result", res_data, res_overflow);
        end else begin
          if ({res_overflow, res_data} !== sb[0]) begin
            bad++;
            $display("FAIL res_value: got ovf=%b data=%0h, required ovf=%b data=%0h",
                     res_overflow, res_data, sb[0][4], sb[0][3:0]);
          end
          sb.delete(0);
        end
      end
      if (err === 1'b1) obs_err++;
    end
    if (watch_push && alu_opcode === 3'b110) saw_push++;
    if (rec_en && tok_ready === 1'b0) tr.push_back({alu_opcode, alu_input_data});
  end

  task automatic model_err();
    exp_err++;
    m_stk.delete();
    m_acc = 1'b0;
  endtask

  // RPN reference: updates the expected stack and queues expected results
  task automatic model_tok(input logic [1:0] t, input logic [3:0] d);
    int a, b, r;
    case (t)
      2'b00: if (m_stk.size() < 64) m_stk.push_back(int'(d)); else model_err();
      2'b01, 2'b10: begin
        if (m_stk.size() >= 2) begin
          a = m_stk.pop_back();
          b = m_stk.pop_back();
          r = (t == 2'b01) ? a + b : a * b;
          if (r > 15) m_acc = 1'b1;
          m_stk.push_back(r % 16);
        end else model_err();
      end
      default: begin
        if (m_stk.size() == 1) begin
          sb.push_back({m_acc, 4'(m_stk.pop_back())});
          m_acc = 1'b0;
        end else model_err();
      end
    endcase
  endtask

  task automatic send_tok(input logic [1:0] t, input logic [3:0] d);
    int n;
    n = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type = t;
    tok_data = d;
    while (tok_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (tok_ready !== 1'b1) begin
      bad++;
      $display("FAIL handshake: tok_ready=%b after %0d cycles, required 1", tok_ready, n);
      tok_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 tok_valid = 1'b0;
      model_tok(t, d);
    end
  endtask

  task automatic wait_results();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL res_timeout: %0d results pending, required 0", sb.size());
    end
  endtask

  task automatic do_reset(output int npop);
    rst_n = 1'b0;
    tok_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    npop = 0;
    while (alu_opcode === 3'b111 && tok_ready === 1'b0 && npop < 200) begin
      npop++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int npop;
    do_reset(npop);
    total++; if (npop != 64) begin bad++; $display("FAIL rst_drain: pops=%0d, required 64", npop); end
    total++; if (tok_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b, required 1", tok_ready); end
    total++; if (depth !== 7'd0) begin bad++; $display("FAIL rst_depth: got %0d, required 0", depth); end
    total++; if (err !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL rst_pulses: err=%b res_valid=%b, required 0 0", err, res_valid); end
    total++; if (res_data !== 4'h0 || res_overflow !== 1'b0) begin bad++; $display("FAIL rst_res: data=%0h ovf=%b, required 0 0", res_data, res_overflow); end
    total++; if (alu_opcode !== 3'b000 || alu_input_data !== 4'h0) begin bad++; $display("FAIL rst_idle_op: op=%b in=%0h, required 000 0", alu_opcode, alu_input_data); end
  endtask

  task automatic test_basic_add();
    logic [6:0] exp_tr [9] = '{7'b110_0011, 7'b110_0010, 7'b100_0000, 7'b000_0000,
                               7'b111_0000, 7'b111_0000, 7'b110_0101, 7'b111_0000, 7'b000_0000};
    tr.delete();
    rec_en = 1'b1;
    send_tok(2'b00, 4'd3);
    send_tok(2'b00, 4'd2);
    send_tok(2'b01, 4'd0);
    send_tok(2'b11, 4'd0);
    wait_results();
    rec_en = 1'b0;
    total++; if (tr.size() != 9) begin bad++; $display("FAIL trace_len: got %0d, required 9", tr.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < tr.size()) begin
        total++;
        if (tr[i] !== exp_tr[i]) begin
          bad++;
          $display("FAIL trace_%0d: got op=%b in=%0h, required op=%b in=%0h", i, tr[i][6:4], tr[i][3:0], exp_tr[i][6:4], exp_tr[i][3:0]);
        end
      end
    end
    total++; if (depth !== 7'd0) begin bad++; $display("FAIL add_depth: got %0d, required 0", depth); end
  endtask

  task automatic test_arith();
    send_tok(2'b00, 4'd3); send_tok(2'b00, 4'd4); send_tok(2'b10, 4'd0);
    send_tok(2'b00, 4'd2); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_results();
    send_tok(2'b00, 4'd9); send_tok(2'b00, 4'd8); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_results();
    send_tok(2'b00, 4'd6); send_tok(2'b00, 4'd7); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_results();
    repeat (3) @(negedge clk);
    total++; if (res_data !== 4'hD || res_overflow !== 1'b0) begin bad++; $display("FAIL res_hold: data=%0h ovf=%b, required d 0", res_data, res_overflow); end
  endtask

  task automatic test_back_to_back();
    send_tok(2'b00, 4'd5); send_tok(2'b00, 4'd5); send_tok(2'b10, 4'd0); send_tok(2'b11, 4'd0);
    send_tok(2'b00, 4'd15); send_tok(2'b00, 4'd1); send_tok(2'b01, 4'd0); send_tok(2'b11, 4'd0);
    wait_results();
    total++; if (res_data !== 4'h0 || res_overflow !== 1'b1) begin bad++; $display("FAIL b2b_last: data=%0h ovf=%b, required 0 1", res_data, res_overflow); end
  endtask

  task automatic test_errors();
    send_tok(2'b00, 4'd7);
    send_tok(2'b01, 4'd0);
    @(negedge clk);
    total++; if (err !== 1'b1 || alu_opcode !== 3'b000) begin bad++; $display("FAIL op_err: err=%b op=%b, required 1 000", err, alu_opcode); end
    @(negedge clk);
    total++; if (alu_opcode !== 3'b111 || err !== 1'b0) begin bad++; $display("FAIL op_flush: op=%b err=%b, required 111 0", alu_opcode, err); end
    @(negedge clk);
    total++; if (tok_ready !== 1'b1 || depth !== 7'd0) begin bad++; $display("FAIL op_recover: ready=%b depth=%0d, required 1 0", tok_ready, depth); end
    send_tok(2'b11, 4'd0);
    @(negedge clk);
    total++; if (err !== 1'b1 || alu_opcode !== 3'b000) begin bad++; $display("FAIL end_err: err=%b op=%b, required 1 000", err, alu_opcode); end
    @(negedge clk);
    total++; if (tok_ready !== 1'b1 || alu_opcode !== 3'b000) begin bad++; $display("FAIL end_nopop: ready=%b op=%b, required 1 000", tok_ready, alu_opcode); end
    @(negedge clk);
    total++; if (obs_err != exp_err) begin bad++; $display("FAIL err_count: got %0d, required %0d", obs_err, exp_err); end
  endtask

  task automatic test_full();
    int n;
    for (int i = 0; i < 64; i++) send_tok(2'b00, 4'(i));
    @(negedge clk);
    @(negedge clk);
    total++; if (depth !== 7'd64) begin bad++; $display("FAIL full_depth: got %0d, required 64", depth); end
    send_tok(2'b00, 4'd5);
    @(negedge clk);
    total++; if (err !== 1'b1 || alu_opcode === 3'b110) begin bad++; $display("FAIL full_err: err=%b op=%b, required 1 and no push", err, alu_opcode); end
    n = 0;
    @(negedge clk);
    while (alu_opcode === 3'b111 && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++; if (n != 64) begin bad++; $display("FAIL full_flush: pops=%0d, required 64", n); end
    total++; if (depth !== 7'd0 || tok_ready !== 1'b1) begin bad++; $display("FAIL full_end: depth=%0d ready=%b, required 0 1", depth, tok_ready); end
    @(negedge clk);
    total++; if (obs_err != exp_err) begin bad++; $display("FAIL full_err_count: got %0d, required %0d", obs_err, exp_err); end
  endtask

  task automatic test_reset_mid();
    int npop;
    int errs_before;
    send_tok(2'b00, 4'd1);
    send_tok(2'b00, 4'd2);
    send_tok(2'b01, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (alu_opcode !== 3'b111 || depth !== 7'd1) begin bad++; $display("FAIL mid_pop2: op=%b depth=%0d, required 111 1", alu_opcode, depth); end
    m_stk.delete();
    m_acc = 1'b0;
    errs_before = obs_err;
    saw_push = 0;
    watch_push = 1'b1;
    do_reset(npop);
    watch_push = 1'b0;
    total++; if (saw_push != 0) begin bad++; $display("FAIL mid_pushr: push cycles=%0d, required 0", saw_push); end
    total++; if (npop != 64) begin bad++; $display("FAIL mid_drain: pops=%0d, required 64", npop); end
    total++; if (depth !== 7'd0 || tok_ready !== 1'b1) begin bad++; $display("FAIL mid_idle: depth=%0d ready=%b, required 0 1", depth, tok_ready); end
    total++; if (res_data !== 4'h0 || obs_err != errs_before) begin bad++; $display("FAIL mid_outputs: data=%0h errs=%0d, required 0 %0d", res_data, obs_err, errs_before); end
    send_tok(2'b00, 4'd4); send_tok(2'b00, 4'd3); send_tok(2'b10, 4'd0); send_tok(2'b11, 4'd0);
    wait_results();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_arith();
    test_back_to_back();
    test_errors();
    test_full();
    test_reset_mid();
    repeat (2) @(negedge clk);
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover: %0d pending, required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
- RPN expression controller in front of STACK_BASED_ALU.
- Accepts a token stream (operand / ADD / MULT / END) over a valid/ready handshake and translates each token into the ALU's push/pop/op opcode sequence.
- Tracks stack depth, detects malformed expressions and returns the final result with a sticky overflow flag.
- Sits between the token source and one STACK_BASED_ALU instance; it is the only driver of the ALU's opcode and input_data.

Parameters:
DATA_WIDTH, 4, operand/result width; matches the ALU.
STACK_SIZE, 64, ALU stack capacity; sets the depth counter range (0..STACK_SIZE).

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous active-low reset
tok_valid  input  1  token present
tok_ready  output  1  sequencer accepts the token this cycle
tok_type  input  2  00 operand, 01 ADD, 10 MULT, 11 END
tok_data  input  DATA_WIDTH  operand value (tok_type=00 only)
alu_opcode  output  3  to ALU: 000 NOP, 100 ADD, 101 MULT, 110 PUSH, 111 POP
alu_input_data  output  DATA_WIDTH  to ALU input_data
alu_output_data  input  DATA_WIDTH  from ALU output_data
alu_overflow  input  1  from ALU overflow
res_valid  output  1  one-cycle pulse; result available
res_data  output  DATA_WIDTH  expression result
res_overflow  output  1  OR of all ALU overflows during the expression
err  output  1  one-cycle pulse; malformed expression detected
depth  output  7  current tracked stack depth (width is clog2(STACK_SIZE+1))

Behaviour:
ALU contract (decided):
- The ALU samples opcode and input_data on each rising edge.
- ADD/MULT read the top two entries without modifying the stack; the result and overflow appear on the following cycle.
- POP removes the top entry and presents it on output_data the following cycle.
- POP on an empty stack is harmless.

Handshake and outputs:
- Transfer occurs when tok_valid && tok_ready. tok_ready=1 only in IDLE.
- alu_opcode and alu_input_data are Moore outputs of the current state. Their default is NOP and alu_input_data=0.

Reset:
- State=INIT, depth=0, overflow accumulator=0.
- res_valid=0, res_data=0, res_overflow=0, err=0, tok_ready=0.
- Reset mid-operation abandons the operation immediately.

FSM:
- INIT: issue POP for STACK_SIZE consecutive cycles, tracked by a counter, to drain stale ALU contents; then IDLE.
- IDLE, handshake on an operand:
  - depth<STACK_SIZE: latch tok_data, go to PUSH.
  - Otherwise: ERR.
- IDLE, handshake on ADD/MULT:
  - depth>=2: latch the operator, go to OP.
  - Otherwise: ERR.
- IDLE, handshake on END:
  - depth==1: FIN_POP.
  - Otherwise: ERR.
- PUSH: opcode 110, input = latched operand; depth+1; go to IDLE. Operand costs 1 non-ready cycle.
- OP: opcode 100 or 101; go to CAP.
- CAP: NOP; tmp <= alu_output_data; acc |= alu_overflow; go to POP1.
- POP1, POP2: opcode 111 each; depth-1 each.
- PUSHR: opcode 110, input=tmp; depth+1; go to IDLE.
- Operator costs 5 non-ready cycles; net depth change is -1.
- FIN_POP: opcode 111; depth-1; go to FIN_CAP.
- FIN_CAP: NOP; register res_data <= alu_output_data, res_overflow <= acc, res_valid <= 1; clear acc; go to IDLE. res_valid is high exactly one cycle (the first IDLE cycle).
- ERR: err=1 for this cycle only; clear acc; if depth>0 go to FLUSH, else IDLE.
- FLUSH: opcode 111 each cycle, depth-1, until depth==0, then IDLE.

Arithmetic and values:
- Results wrap modulo 2^DATA_WIDTH, as produced by the ALU. The sequencer does no arithmetic except depth ±1.
- res_data holds its value until the next result. res_overflow likewise.

Boundaries:
- Operand at depth==STACK_SIZE raises an error; no push is issued.
- Operator at depth 0 or 1 raises an error.
- END at depth 0 or >1 raises an error.
- Tokens presented while tok_ready=0 are not consumed; the source must hold them stable.
- depth never underflows or exceeds STACK_SIZE.

Test Plan:
1. Reset (rst_n low 2 cycles) -> exactly 64 cycles of opcode 111 with tok_ready=0, then tok_ready=1, depth=0, no err/res_valid.
2. Tokens 3, 2, ADD, END with tok_valid held -> opcode trace 110(3), 110(2), 100, 000, 111, 111, 110(5), 111, 000. Then res_valid pulse with res_data=5, res_overflow=0, depth=0.
3. Tokens 3, 4, MULT, 2, ADD, END -> res_data=0xE, res_overflow=0. Tokens 9, 8, ADD, END with the ALU asserting overflow -> res_data=1, res_overflow=1. res_overflow returns to 0 on the next clean expression.
4. Tokens 7, ADD -> err pulse the cycle after ADD is accepted, then one POP (FLUSH), depth=0, no res_valid, tok_ready back to 1. Then END at depth 0 -> err with no POP.
5. Push 64 operands, then a 65th operand -> err, 64 FLUSH pops, depth=0.
6. Assert rst_n low during POP2 of an ADD sequence -> no PUSHR issued, no res_valid, and the INIT drain restarts from the beginning.
